// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of a register file, with one registered
// write stage, read-port bypass from that stage and a counter of dropped x0 writes.
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 rf_we,
    output logic [4:0]           rf_addr_w,
    output logic [XLEN-1:0]      rf_data_w,
    input  logic [4:0]           rd_addr1,
    input  logic [4:0]           rd_addr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [XLEN-1:0]      fwd_data1,
    output logic [XLEN-1:0]      fwd_data2,
    output logic [15:0]          drop_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic            found;
    logic            accept;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    // Reduce a sum of two in-range indices back into 0..NREQ-1.
    function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
        logic [PW:0] t;
        t = (v >= (PW+1)'(NREQ)) ? v - (PW+1)'(NREQ) : v;
        return t[PW-1:0];
    endfunction

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[wrap({1'b0, rr_ptr} + (PW+1)'(i))]) begin
                found = 1'b1;
                gidx  = wrap({1'b0, rr_ptr} + (PW+1)'(i));
            end
        end
        accept    = found && !flush;
        req_ready = accept ? (NREQ'(1) << gidx) : '0;
        sel_addr  = req_addr[5*gidx +: 5];
        sel_data  = req_data[XLEN*gidx +: XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= wrap({1'b0, gidx} + (PW+1)'(1));
        end
    end

    // Writes to x0 consume the grant but never reach the staged port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_addr_w <= '0;
            rf_data_w <= '0;
        end else begin
            rf_we <= accept && (sel_addr != 5'd0);
            if (accept && (sel_addr != 5'd0)) begin
                rf_addr_w <= sel_addr;
                rf_data_w <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (accept && (sel_addr == 5'd0) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign fwd_hit1  = rf_we && (rd_addr1 == rf_addr_w) && (rd_addr1 != 5'd0);
    assign fwd_hit2  = rf_we && (rd_addr2 == rf_addr_w) && (rd_addr2 != 5'd0);
    assign fwd_data1 = fwd_hit1 ? rf_data_w : '0;
    assign fwd_data2 = fwd_hit2 ? rf_data_w : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against
// a behavioural model of the arbitration, staging, bypass and drop-counter rules.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_addr;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 flush;
    logic                 rf_we;
    logic [4:0]           rf_addr_w;
    logic [XLEN-1:0]      rf_data_w;
    logic [4:0]           rd_addr1, rd_addr2;
    logic                 fwd_hit1, fwd_hit2;
    logic [XLEN-1:0]      fwd_data1, fwd_data2;
    logic [15:0]          drop_cnt;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .flush(flush), .rf_we(rf_we),
        .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int              m_ptr;
    int              m_drop;
    bit              m_we;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;

    function automatic int exp_grant();
        if (flush) return -1;
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_drop = 0; m_we = 0; m_addr = '0; m_data = '0;
    endtask

    // Advance one clock: model consumes the current inputs, DUT sees the edge.
    task automatic tick();
        int g;
        logic [4:0] a;
        logic [XLEN-1:0] d;
        g = exp_grant();
        a = '0; d = '0;
        if (g >= 0) begin
            a = req_addr[5*g +: 5];
            d = req_data[XLEN*g +: XLEN];
        end
        @(posedge clk);
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (a != 0) begin
                m_we = 1; m_addr = a; m_data = d;
            end else begin
                m_we = 0;
                if (m_drop < 65535) m_drop++;
            end
        end else begin
            m_we = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_data = '0; flush = 0;
        rd_addr1 = '0; rd_addr2 = '0;
    endtask

    task automatic pulse_reset();
        reset = 1; #1; reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #2;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        vectors++; if (rf_addr_w !== 5'd0) begin miscompares++; $display("FAIL reset_rf_addr got %0d want 0", rf_addr_w); end
        vectors++; if (rf_data_w !== '0) begin miscompares++; $display("FAIL reset_rf_data got %h want 0", rf_data_w); end
        vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready got %b want 0", req_ready); end
        vectors++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== '0) begin miscompares++; $display("FAIL reset_fwd1 got %0b/%h want 0/0", fwd_hit1, fwd_data1); end
        @(negedge clk);
        reset = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle_inputs();
        req_valid = 3'b001;
        req_addr[4:0] = 5'd5;
        req_data[XLEN-1:0] = 64'hDEAD_BEEF;
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        #1;
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL single_ready got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL single_we got %0b want 1", rf_we); end
        vectors++; if (rf_addr_w !== 5'd5) begin miscompares++; $display("FAIL single_addr got %0d want 5", rf_addr_w); end
        vectors++; if (rf_data_w !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data got %h want deadbeef", rf_data_w); end
        vectors++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL single_fwd1 got %0b/%h want 1/deadbeef", fwd_hit1, fwd_data1); end
        vectors++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== '0) begin miscompares++; $display("FAIL single_fwd2 got %0b/%h want 0/0", fwd_hit2, fwd_data2); end
        tick();
        vectors++; if (rf_we !== 1'b0 || rf_addr_w !== 5'd5) begin miscompares++; $display("FAIL single_hold got we=%0b addr=%0d want 0/5", rf_we, rf_addr_w); end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        pulse_reset();
        req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[5*i +: 5] = 5'(i + 1);
            req_data[XLEN*i +: XLEN] = {$urandom, $urandom};
        end
        for (int k = 0; k < 9; k++) begin
            logic [NREQ-1:0] want;
            want = '0; want[k % NREQ] = 1'b1;
            #1;
            vectors++; if (req_ready !== want) begin miscompares++; $display("FAIL rr_ready cyc %0d got %b want %b", k, req_ready, want); end
            tick();
            vectors++; if (rf_we !== 1'b1 || rf_addr_w !== 5'((k % NREQ) + 1)) begin miscompares++; $display("FAIL rr_write cyc %0d got we=%0b addr=%0d want 1/%0d", k, rf_we, rf_addr_w, (k % NREQ) + 1); end
        end
    endtask

    task automatic test_same_addr();
        logic [XLEN-1:0] da, db;
        idle_inputs();
        pulse_reset();
        da = {$urandom, $urandom}; db = {$urandom, $urandom};
        req_valid = 3'b011;
        req_addr[4:0] = 5'd7; req_addr[9:5] = 5'd7;
        req_data[XLEN-1:0] = da; req_data[2*XLEN-1:XLEN] = db;
        tick();
        req_valid = 3'b010;
        #1;
        vectors++; if (rf_data_w !== da || rf_we !== 1'b1) begin miscompares++; $display("FAIL same_first got %h want %h", rf_data_w, da); end
        tick();
        req_valid = '0;
        #1;
        vectors++; if (rf_data_w !== db || rf_addr_w !== 5'd7) begin miscompares++; $display("FAIL same_second got %h want %h", rf_data_w, db); end
    endtask

    task automatic test_flush();
        idle_inputs();
        req_valid = 3'b100;
        req_addr[14:10] = 5'd12;
        req_data[3*XLEN-1:2*XLEN] = {$urandom, $urandom};
        flush = 1;
        #1;
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL flush_ready got %b want 000", req_ready); end
        tick();
        flush = 0;
        #1;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_we got %0b want 0", rf_we); end
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL flush_regrant got %b want 100", req_ready); end
        tick();
        req_valid = '0;
        vectors++; if (rf_we !== 1'b1 || rf_addr_w !== 5'd12) begin miscompares++; $display("FAIL flush_write got we=%0b addr=%0d want 1/12", rf_we, rf_addr_w); end
    endtask

    task automatic test_random();
        int g;
        idle_inputs();
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_addr[5*i +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_data[XLEN*i +: XLEN] = {$urandom, $urandom};
                end
            end
            flush = ($urandom_range(0, 5) == 0);
            rd_addr1 = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
            rd_addr2 = $urandom_range(0, 2) == 0 ? m_addr : 5'($urandom_range(0, 31));
            #1;
            vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, req_ready, exp_ready()); end
            vectors++; if (rf_we !== m_we) begin miscompares++; $display("FAIL rnd_we cyc %0d got %0b want %0b", c, rf_we, m_we); end
            vectors++; if (rf_addr_w !== m_addr || rf_data_w !== m_data) begin miscompares++; $display("FAIL rnd_stage cyc %0d got %0d/%h want %0d/%h", c, rf_addr_w, rf_data_w, m_addr, m_data); end
            vectors++;
            if (fwd_hit1 !== (m_we && rd_addr1 == m_addr && rd_addr1 != 0) ||
                fwd_data1 !== ((m_we && rd_addr1 == m_addr && rd_addr1 != 0) ? m_data : '0)) begin
                miscompares++; $display("FAIL rnd_fwd1 cyc %0d got %0b/%h", c, fwd_hit1, fwd_data1);
            end
            vectors++;
            if (fwd_hit2 !== (m_we && rd_addr2 == m_addr && rd_addr2 != 0) ||
                fwd_data2 !== ((m_we && rd_addr2 == m_addr && rd_addr2 != 0) ? m_data : '0)) begin
                miscompares++; $display("FAIL rnd_fwd2 cyc %0d got %0b/%h", c, fwd_hit2, fwd_data2);
            end
            vectors++; if (drop_cnt !== 16'(m_drop)) begin miscompares++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", c, drop_cnt, m_drop); end
            g = exp_grant();
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_drop_saturate();
        idle_inputs();
        pulse_reset();
        req_valid = 3'b010;
        req_addr[9:5] = 5'd0;
        rd_addr1 = 5'd0;
        for (int c = 0; c < 65600; c++) begin
            tick();
            vectors++; if (rf_we !== 1'b0 || fwd_hit1 !== 1'b0) begin miscompares++; $display("FAIL sat_we cyc %0d got we=%0b hit=%0b want 0/0", c, rf_we, fwd_hit1); end
            vectors++; if (drop_cnt !== 16'(m_drop)) begin miscompares++; $display("FAIL sat_cnt cyc %0d got %0d want %0d", c, drop_cnt, m_drop); end
        end
        vectors++; if (drop_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_final got %h want ffff", drop_cnt); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        pulse_reset();
        req_valid = 3'b001;
        for (int c = 0; c < 7; c++) tick();
        req_addr[4:0] = 5'd9;
        req_data[XLEN-1:0] = {$urandom, $urandom};
        rd_addr1 = 5'd9;
        tick();
        req_valid = '0;
        vectors++; if (rf_we !== 1'b1 || drop_cnt !== 16'd7) begin miscompares++; $display("FAIL mid_setup got we=%0b drop=%0d want 1/7", rf_we, drop_cnt); end
        #2;
        reset = 1;
        #1;
        vectors++; if (rf_we !== 1'b0 || rf_addr_w !== 5'd0 || rf_data_w !== '0) begin miscompares++; $display("FAIL mid_stage got %0b/%0d/%h want 0/0/0", rf_we, rf_addr_w, rf_data_w); end
        vectors++; if (drop_cnt !== 16'd0 || fwd_hit1 !== 1'b0) begin miscompares++; $display("FAIL mid_drop got %0d hit=%0b want 0/0", drop_cnt, fwd_hit1); end
        #1;
        reset = 0;
        model_reset();
        req_valid = 3'b110;
        #1;
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL mid_first_grant got %b want 010", req_ready); end
        tick();
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL mid_second_grant got %b want 100", req_ready); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_same_addr();
        test_flush();
        test_random();
        test_drop_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
